// File: rtl/triad_output_arbiter.sv
// -----------------------------------------------------------------------------
// triad_output_arbiter
//
// Shares one valid/ready output channel between NB_TRIADS triad_manager
// instances. Each triad's 102-bit sensor_iterations word is captured into a
// one-deep holding slot on its data_avl pulse. Full slots are granted
// round-robin. After the downstream accepts a word, the owning triad receives
// a one-cycle reset_parser pulse that re-arms its parser.
//
// Optional feature macro: TRIAD_TIMESTAMP_EN
//   When defined, sys_ts is captured per slot (including on overwrite) and
//   presented on out_ts alongside the granted word. When undefined, the
//   sys_ts/out_ts ports and all timestamp registers are absent.
//
// Ports:
//   clk_72MHz               in   system clock
//   reset                   in   synchronous, active-high reset
//   triad_data_avl          in   per-triad one-cycle data_avl pulse
//   triad_sensor_iterations in   concatenated words, triad i at [i*102 +: 102]
//   triad_reset_parser      out  one-cycle reset_parser pulse per triad
//   out_valid / out_ready        output handshake
//   out_data                out  granted sensor_iterations word
//   out_triad_id            out  index of the granted triad
//   out_ts                  out  capture timestamp (TRIAD_TIMESTAMP_EN only)
//   sys_ts                  in   system timestamp (TRIAD_TIMESTAMP_EN only)
//   overflow_count          out  words overwritten before grant (saturating)
//   drop_count              out  words discarded by timeout (saturating)
// -----------------------------------------------------------------------------
module triad_output_arbiter #(
  parameter int NB_TRIADS      = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 72000
) (
  input  logic                    clk_72MHz,
  input  logic                    reset,
  input  logic [NB_TRIADS-1:0]    triad_data_avl,
  input  logic [NB_TRIADS*102-1:0] triad_sensor_iterations,
  output logic [NB_TRIADS-1:0]    triad_reset_parser,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [101:0]            out_data,
  output logic [ID_W-1:0]         out_triad_id,
`ifdef TRIAD_TIMESTAMP_EN
  output logic [23:0]             out_ts,
  input  logic [23:0]             sys_ts,
`endif
  output logic [15:0]             overflow_count,
  output logic [15:0]             drop_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    RELEASE = 2'd2
  } state_e;

  // Age counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int AGE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [AGE_W-1:0] AGE_LAST =
    (TIMEOUT_CYCLES > 0) ? AGE_W'(TIMEOUT_CYCLES - 1) : {AGE_W{1'b0}};
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  // Saturating add of a per-cycle event count to a 16-bit counter.
  function automatic logic [15:0] sat_add(input logic [15:0] acc, input logic [3:0] inc);
    logic [16:0] sum;
    sum = {1'b0, acc} + {13'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  state_e                 state_q, state_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]        sel_q, sel_d;
  logic [NB_TRIADS-1:0]   full_q, full_d;
  logic [101:0]           slot_q [NB_TRIADS];
  logic [101:0]           slot_d [NB_TRIADS];
  logic [AGE_W-1:0]       age_q  [NB_TRIADS];
  logic [AGE_W-1:0]       age_d  [NB_TRIADS];
  logic                   out_valid_q, out_valid_d;
  logic [101:0]           out_data_q, out_data_d;
  logic [ID_W-1:0]        out_triad_id_q, out_triad_id_d;
  logic [NB_TRIADS-1:0]   reset_parser_q, reset_parser_d;
  logic [15:0]            overflow_count_q, overflow_count_d;
  logic [15:0]            drop_count_q, drop_count_d;
`ifdef TRIAD_TIMESTAMP_EN
  logic [23:0]            ts_q [NB_TRIADS];
  logic [23:0]            ts_d [NB_TRIADS];
  logic [23:0]            out_ts_q, out_ts_d;
`endif

  logic                   pick_found;
  logic [ID_W-1:0]        pick_idx;
  logic [ID_W:0]          cand_raw;
  logic [ID_W:0]          cand;
  logic                   grant;
  logic [3:0]             ovf_n;
  logic [3:0]             drop_n;

  // Round-robin search: walk from the highest offset down so the lowest
  // offset from rr_ptr (first in search order) is the last, winning write.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_ptr_q;
    cand_raw   = {(ID_W+1){1'b0}};
    cand       = {(ID_W+1){1'b0}};
    for (int k = NB_TRIADS - 1; k >= 0; k--) begin
      cand_raw   = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      cand       = (cand_raw >= (ID_W+1)'(NB_TRIADS)) ? (cand_raw - (ID_W+1)'(NB_TRIADS)) : cand_raw;
      pick_idx   = full_q[cand[ID_W-1:0]] ? cand[ID_W-1:0] : pick_idx;
      pick_found = pick_found | full_q[cand[ID_W-1:0]];
    end
  end

  // Grant FSM: next state, output register loads and reset_parser pulse.
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    sel_d          = sel_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    out_triad_id_d = out_triad_id_q;
    reset_parser_d = {NB_TRIADS{1'b0}};
    grant          = 1'b0;
`ifdef TRIAD_TIMESTAMP_EN
    out_ts_d       = out_ts_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant          = 1'b1;
          sel_d          = pick_idx;
          out_data_d     = slot_q[pick_idx];
          out_triad_id_d = pick_idx;
          out_valid_d    = 1'b1;
`ifdef TRIAD_TIMESTAMP_EN
          out_ts_d       = ts_q[pick_idx];
`endif
          state_d        = PRESENT;
        end else begin
          state_d = IDLE;
        end
      end
      PRESENT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d           = 1'b0;
          reset_parser_d[sel_q] = 1'b1;
          rr_ptr_d = (sel_q == ID_W'(NB_TRIADS - 1)) ? {ID_W{1'b0}} : (sel_q + {{(ID_W-1){1'b0}}, 1'b1});
          state_d  = RELEASE;
        end else begin
          state_d = PRESENT;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Slot bookkeeping: capture beats grant/timeout; grant beats timeout.
  always_comb begin
    ovf_n  = 4'd0;
    drop_n = 4'd0;
    full_d = full_q;
    for (int i = 0; i < NB_TRIADS; i++) begin
      slot_d[i] = slot_q[i];
      age_d[i]  = age_q[i];
`ifdef TRIAD_TIMESTAMP_EN
      ts_d[i]   = ts_q[i];
`endif
      if (triad_data_avl[i]) begin
        // A capture on the slot being granted keeps the new word queued and
        // is not an overflow: the old word is leaving via the grant.
        ovf_n     = ovf_n + {3'b000, (full_q[i] && !(grant && (pick_idx == ID_W'(i))))};
        slot_d[i] = triad_sensor_iterations[i*102 +: 102];
        full_d[i] = 1'b1;
        age_d[i]  = {AGE_W{1'b0}};
`ifdef TRIAD_TIMESTAMP_EN
        ts_d[i]   = sys_ts;
`endif
      end else if (full_q[i]) begin
        if (grant && (pick_idx == ID_W'(i))) begin
          full_d[i] = 1'b0;
          age_d[i]  = {AGE_W{1'b0}};
        end else if (TIMEOUT_EN && (age_q[i] == AGE_LAST)) begin
          full_d[i] = 1'b0;
          age_d[i]  = {AGE_W{1'b0}};
          drop_n    = drop_n + 4'd1;
        end else if (TIMEOUT_EN) begin
          age_d[i] = age_q[i] + {{(AGE_W-1){1'b0}}, 1'b1};
        end else begin
          age_d[i] = age_q[i];
        end
      end else begin
        age_d[i] = age_q[i];
      end
    end
    overflow_count_d = sat_add(overflow_count_q, ovf_n);
    drop_count_d     = sat_add(drop_count_q, drop_n);
  end

  // State register with synchronous reset; reset drops any transfer silently.
  always_ff @(posedge clk_72MHz) begin
    if (reset) begin
      state_q          <= IDLE;
      rr_ptr_q         <= {ID_W{1'b0}};
      sel_q            <= {ID_W{1'b0}};
      full_q           <= {NB_TRIADS{1'b0}};
      out_valid_q      <= 1'b0;
      out_data_q       <= 102'd0;
      out_triad_id_q   <= {ID_W{1'b0}};
      reset_parser_q   <= {NB_TRIADS{1'b0}};
      overflow_count_q <= 16'd0;
      drop_count_q     <= 16'd0;
`ifdef TRIAD_TIMESTAMP_EN
      out_ts_q         <= 24'd0;
`endif
      for (int i = 0; i < NB_TRIADS; i++) begin
        slot_q[i] <= 102'd0;
        age_q[i]  <= {AGE_W{1'b0}};
`ifdef TRIAD_TIMESTAMP_EN
        ts_q[i]   <= 24'd0;
`endif
      end
    end else begin
      state_q          <= state_d;
      rr_ptr_q         <= rr_ptr_d;
      sel_q            <= sel_d;
      full_q           <= full_d;
      out_valid_q      <= out_valid_d;
      out_data_q       <= out_data_d;
      out_triad_id_q   <= out_triad_id_d;
      reset_parser_q   <= reset_parser_d;
      overflow_count_q <= overflow_count_d;
      drop_count_q     <= drop_count_d;
`ifdef TRIAD_TIMESTAMP_EN
      out_ts_q         <= out_ts_d;
`endif
      for (int i = 0; i < NB_TRIADS; i++) begin
        slot_q[i] <= slot_d[i];
        age_q[i]  <= age_d[i];
`ifdef TRIAD_TIMESTAMP_EN
        ts_q[i]   <= ts_d[i];
`endif
      end
    end
  end

  assign out_valid          = out_valid_q;
  assign out_data           = out_data_q;
  assign out_triad_id       = out_triad_id_q;
  assign triad_reset_parser = reset_parser_q;
  assign overflow_count     = overflow_count_q;
  assign drop_count         = drop_count_q;
`ifdef TRIAD_TIMESTAMP_EN
  assign out_ts             = out_ts_q;
`endif

endmodule

// File: tb/tb_triad_output_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for triad_output_arbiter (NB_TRIADS=4, ID_W=2, TIMEOUT_CYCLES=100).
// Inputs are driven on the falling edge; outputs are sampled on the following
// falling edge, i.e. half a cycle after the rising edge that produced them.
// -----------------------------------------------------------------------------
module tb_triad_output_arbiter;

  logic          clk;
  logic          reset;
  logic [3:0]    triad_data_avl;
  logic [407:0]  triad_sensor_iterations;
  logic [3:0]    triad_reset_parser;
  logic          out_valid;
  logic          out_ready;
  logic [101:0]  out_data;
  logic [1:0]    out_triad_id;
  logic [15:0]   overflow_count;
  logic [15:0]   drop_count;
`ifdef TRIAD_TIMESTAMP_EN
  logic [23:0]   out_ts;
  logic [23:0]   sys_ts;
`endif

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  triad_output_arbiter #(
    .NB_TRIADS(4),
    .ID_W(2),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk_72MHz(clk),
    .reset(reset),
    .triad_data_avl(triad_data_avl),
    .triad_sensor_iterations(triad_sensor_iterations),
    .triad_reset_parser(triad_reset_parser),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_triad_id(out_triad_id),
`ifdef TRIAD_TIMESTAMP_EN
    .out_ts(out_ts),
    .sys_ts(sys_ts),
`endif
    .overflow_count(overflow_count),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              rst;
    logic [3:0]        avl;
    logic [3:0][101:0] w;
    logic              ready;
    logic              exp_valid;
    logic [101:0]      exp_data;
    logic [1:0]        exp_id;
    logic [3:0]        exp_rp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic [3:0] avl,
                              input logic [3:0][101:0] w, input logic ready,
                              input logic ev, input logic [101:0] ed,
                              input logic [1:0] eid, input logic [3:0] erp);
    vec_t v;
    v.rst = rst; v.avl = avl; v.w = w; v.ready = ready;
    v.exp_valid = ev; v.exp_data = ed; v.exp_id = eid; v.exp_rp = erp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [101:0] act, input logic [101:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_lane(input int i, input logic [101:0] w);
    triad_sensor_iterations[i*102 +: 102] = w;
  endtask

  localparam logic [101:0] Z1   = 102'd0;
  localparam logic [101:0] WABC = 102'h1ABC;
  localparam logic [101:0] R0 = 102'h1000_0000_0000_0000_0A00;
  localparam logic [101:0] R1 = 102'h2000_0000_0000_0000_0A01;
  localparam logic [101:0] R2 = 102'h3000_0000_0000_0000_0A02;
  localparam logic [101:0] R3 = 102'h3_F000_0000_0000_0000_0A03;
  localparam logic [101:0] S0 = 102'h0555_5555_5555;
  localparam logic [101:0] X0 = 102'h2_0000_0000_0000_0000_0000_0B00;
  localparam logic [101:0] X1 = 102'h0B01;
  localparam logic [101:0] X2 = 102'hBEEF_0B02;
  localparam logic [101:0] X3 = 102'h1_2345_6789_0B03;

  initial begin
    logic [3:0][101:0] wz, w2, wr, ws, wx;
    reset = 1'b1;
    triad_data_avl = 4'd0;
    triad_sensor_iterations = 408'd0;
    out_ready = 1'b1;
`ifdef TRIAD_TIMESTAMP_EN
    sys_ts = 24'd0;
`endif
    wz = {Z1, Z1, Z1, Z1};
    w2 = {Z1, WABC, Z1, Z1};
    wr = {R3, R2, R1, R0};
    ws = {Z1, Z1, Z1, S0};
    wx = {X3, X2, X1, X0};

    // Single capture on triad 2, then a full round of four, then a refill
    // after rr_ptr has moved to 1.
    vecs.push_back(mk(1'b1, 4'b0000, wz, 1'b1, 1'b0, Z1,   2'd0, 4'b0000));
    vecs.push_back(mk(1'b0, 4'b0000, wz, 1'b1, 1'b0, Z1,   2'd0, 4'b0000));
    vecs.push_back(mk(1'b0, 4'b0100, w2, 1'b1, 1'b0, Z1,   2'd0, 4'b0000));
    vecs.push_back(mk(1'b0, 4'b0000, wz, 1'b1, 1'b1, WABC, 2'd2, 4'b0000));
    vecs.push_back(mk(1'b0, 4'b0000, wz, 1'b1, 1'b0, WABC, 2'd2, 4'b0100));
    vecs.push_back(mk(1'b0, 4'b0000, wz, 1'b1, 1'b0, WABC, 2'd2, 4'b0000));
    vecs.push_back(mk(1'b1, 4'b0000, wz, 1'b1, 1'b0, Z1,   2'd0, 4'b0000));
    vecs.push_back(mk(1'b0, 4'b1111, wr, 1'b1, 1'b0, Z1,   2'd0, 4'b0000));
    vecs.push_back(mk(1'b0, 4'b0000, wz, 1'b1, 1'b1, R0,   2'd0, 4'b0000));
    vecs.push_back(mk(1'b0, 4'b0000, wz, 1'b1, 1'b0, R0,   2'd0, 4'b0001));
    vecs.push_back(mk(1'b0, 4'b0000, wz, 1'b1, 1'b0, R0,   2'd0, 4'b0000));
    vecs.push_back(mk(1'b0, 4'b0000, wz, 1'b1, 1'b1, R1,   2'd1, 4'b0000));
    vecs.push_back(mk(1'b0, 4'b0000, wz, 1'b1, 1'b0, R1,   2'd1, 4'b0010));
    vecs.push_back(mk(1'b0, 4'b0000, wz, 1'b1, 1'b0, R1,   2'd1, 4'b0000));
    vecs.push_back(mk(1'b0, 4'b0000, wz, 1'b1, 1'b1, R2,   2'd2, 4'b0000));
    vecs.push_back(mk(1'b0, 4'b0000, wz, 1'b1, 1'b0, R2,   2'd2, 4'b0100));
    vecs.push_back(mk(1'b0, 4'b0000, wz, 1'b1, 1'b0, R2,   2'd2, 4'b0000));
    vecs.push_back(mk(1'b0, 4'b0000, wz, 1'b1, 1'b1, R3,   2'd3, 4'b0000));
    vecs.push_back(mk(1'b0, 4'b0000, wz, 1'b1, 1'b0, R3,   2'd3, 4'b1000));
    vecs.push_back(mk(1'b0, 4'b0000, wz, 1'b1, 1'b0, R3,   2'd3, 4'b0000));
    vecs.push_back(mk(1'b0, 4'b0001, ws, 1'b1, 1'b0, R3,   2'd3, 4'b0000));
    vecs.push_back(mk(1'b0, 4'b0000, wz, 1'b1, 1'b1, S0,   2'd0, 4'b0000));
    vecs.push_back(mk(1'b0, 4'b0000, wz, 1'b1, 1'b0, S0,   2'd0, 4'b0001));
    vecs.push_back(mk(1'b0, 4'b1111, wx, 1'b1, 1'b0, S0,   2'd0, 4'b0000));
    vecs.push_back(mk(1'b0, 4'b0000, wz, 1'b1, 1'b1, X1,   2'd1, 4'b0000));
    vecs.push_back(mk(1'b0, 4'b0000, wz, 1'b1, 1'b0, X1,   2'd1, 4'b0010));
    vecs.push_back(mk(1'b0, 4'b0000, wz, 1'b1, 1'b0, X1,   2'd1, 4'b0000));
    vecs.push_back(mk(1'b0, 4'b0000, wz, 1'b1, 1'b1, X2,   2'd2, 4'b0000));
    vecs.push_back(mk(1'b0, 4'b0000, wz, 1'b1, 1'b0, X2,   2'd2, 4'b0100));
    vecs.push_back(mk(1'b0, 4'b0000, wz, 1'b1, 1'b0, X2,   2'd2, 4'b0000));
    vecs.push_back(mk(1'b0, 4'b0000, wz, 1'b1, 1'b1, X3,   2'd3, 4'b0000));
    vecs.push_back(mk(1'b0, 4'b0000, wz, 1'b1, 1'b0, X3,   2'd3, 4'b1000));
    vecs.push_back(mk(1'b0, 4'b0000, wz, 1'b1, 1'b0, X3,   2'd3, 4'b0000));
    vecs.push_back(mk(1'b0, 4'b0000, wz, 1'b1, 1'b1, X0,   2'd0, 4'b0000));
    vecs.push_back(mk(1'b0, 4'b0000, wz, 1'b1, 1'b0, X0,   2'd0, 4'b0001));
    vecs.push_back(mk(1'b0, 4'b0000, wz, 1'b1, 1'b0, X0,   2'd0, 4'b0000));

    for (int r = 0; r < vecs.size(); r++) begin
      reset = vecs[r].rst;
      triad_data_avl = vecs[r].avl;
      triad_sensor_iterations = vecs[r].w;
      out_ready = vecs[r].ready;
      tick();
      chk($sformatf("row%0d valid", r), {101'd0, out_valid}, {101'd0, vecs[r].exp_valid});
      chk($sformatf("row%0d data", r), out_data, vecs[r].exp_data);
      chk($sformatf("row%0d id", r), {100'd0, out_triad_id}, {100'd0, vecs[r].exp_id});
      chk($sformatf("row%0d reset_parser", r), {98'd0, triad_reset_parser}, {98'd0, vecs[r].exp_rp});
    end
    chk("table overflow_count", {86'd0, overflow_count}, 102'd0);
    chk("table drop_count", {86'd0, drop_count}, 102'd0);

    // Backpressure: triad 1 re-pulses while its first word is stalled.
    reset = 1'b1; triad_data_avl = 4'd0; out_ready = 1'b0;
    triad_sensor_iterations = 408'd0;
    tick();
    reset = 1'b0;
    set_lane(1, 102'hB1B1_0001);
`ifdef TRIAD_TIMESTAMP_EN
    sys_ts = 24'h00_1234;
`endif
    triad_data_avl = 4'b0010;
    tick();
    triad_data_avl = 4'b0000;
    tick();
    chk("bp grant valid", {101'd0, out_valid}, 102'd1);
    chk("bp grant data", out_data, 102'hB1B1_0001);
    chk("bp grant id", {100'd0, out_triad_id}, 102'd1);
    for (int c = 0; c < 50; c++) begin
      if (c == 10) begin
        set_lane(1, 102'hB2B2_0002);
`ifdef TRIAD_TIMESTAMP_EN
        sys_ts = 24'h00_ABCD;
`endif
        triad_data_avl = 4'b0010;
      end else begin
        triad_data_avl = 4'b0000;
      end
      tick();
      chk($sformatf("bp stall%0d data", c), out_data, 102'hB1B1_0001);
      chk($sformatf("bp stall%0d valid", c), {101'd0, out_valid}, 102'd1);
    end
    triad_data_avl = 4'b0000;
    chk("bp overflow_count", {86'd0, overflow_count}, 102'd0);
`ifdef TRIAD_TIMESTAMP_EN
    chk("bp out_ts first", {78'd0, out_ts}, {78'd0, 24'h00_1234});
`endif
    out_ready = 1'b1;
    tick();
    chk("bp accept rp", {98'd0, triad_reset_parser}, {98'd0, 4'b0010});
    chk("bp accept valid", {101'd0, out_valid}, 102'd0);
    tick();
    chk("bp release rp", {98'd0, triad_reset_parser}, 102'd0);
    tick();
    chk("bp reserve valid", {101'd0, out_valid}, 102'd1);
    chk("bp reserve data", out_data, 102'hB2B2_0002);
    chk("bp reserve id", {100'd0, out_triad_id}, 102'd1);
`ifdef TRIAD_TIMESTAMP_EN
    chk("bp out_ts second", {78'd0, out_ts}, {78'd0, 24'h00_ABCD});
`endif

    // Overflow: triad 3 pulses three times behind a stalled grant of triad 0.
    reset = 1'b1; out_ready = 1'b0; triad_data_avl = 4'd0;
    tick();
    reset = 1'b0;
    set_lane(0, 102'hA0A0);
    triad_data_avl = 4'b0001;
    tick();
    triad_data_avl = 4'b0000;
    tick();
    chk("ovf grant data", out_data, 102'hA0A0);
    triad_data_avl = 4'b1000;
    set_lane(3, 102'hC1); tick();
    set_lane(3, 102'hC2); tick();
    set_lane(3, 102'hC3); tick();
    triad_data_avl = 4'b0000;
    chk("ovf overflow_count", {86'd0, overflow_count}, 102'd2);
    out_ready = 1'b1;
    tick();
    chk("ovf accept rp", {98'd0, triad_reset_parser}, {98'd0, 4'b0001});
    tick();
    tick();
    chk("ovf last valid", {101'd0, out_valid}, 102'd1);
    chk("ovf last data", out_data, 102'hC3);
    chk("ovf last id", {100'd0, out_triad_id}, 102'd3);

    // Grant and capture on the same slot in one edge.
    reset = 1'b1; out_ready = 1'b1; triad_data_avl = 4'd0;
    tick();
    reset = 1'b0;
    set_lane(0, 102'h6161);
    triad_data_avl = 4'b0001;
    tick();
    set_lane(0, 102'h6262);
    tick();
    triad_data_avl = 4'b0000;
    chk("same-edge granted old", out_data, 102'h6161);
    chk("same-edge no overflow", {86'd0, overflow_count}, 102'd0);
    tick();
    tick();
    tick();
    chk("same-edge new valid", {101'd0, out_valid}, 102'd1);
    chk("same-edge new data", out_data, 102'h6262);
    chk("same-edge new id", {100'd0, out_triad_id}, 102'd0);

    // Timeout: slot 0 granted and stalled, slot 1 ages out after 100 cycles.
    reset = 1'b1; out_ready = 1'b0; triad_data_avl = 4'd0;
    tick();
    reset = 1'b0;
    set_lane(0, 102'h7070);
    set_lane(1, 102'h7171);
    triad_data_avl = 4'b0011;
    tick();
    triad_data_avl = 4'b0000;
    for (int k = 1; k < 100; k++) begin
      tick();
    end
    chk("to before limit drop_count", {86'd0, drop_count}, 102'd0);
    chk("to stalled data", out_data, 102'h7070);
    tick();
    chk("to at limit drop_count", {86'd0, drop_count}, 102'd1);
    chk("to still valid", {101'd0, out_valid}, 102'd1);

    // Reset mid-stall, with out_ready raised on the same edge.
    reset = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("rst valid", {101'd0, out_valid}, 102'd0);
    chk("rst reset_parser", {98'd0, triad_reset_parser}, 102'd0);
    chk("rst drop_count", {86'd0, drop_count}, 102'd0);
    chk("rst data", out_data, 102'd0);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("post-rst%0d reset_parser", k), {98'd0, triad_reset_parser}, 102'd0);
      chk($sformatf("post-rst%0d valid", k), {101'd0, out_valid}, 102'd0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
